// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : cond_flag_unit
// Brief   : ARM NZCV flag register (masked write, shadow save/restore, write
//           bypass) with a multi-lane condition-code evaluator and an optional
//           valid/ready output register.
// Revision: 1.0
// ============================================================================
module cond_flag_unit #(
  parameter int LANES   = 2,
  parameter int PIPE    = 1,
  parameter int BYPASS  = 1,
  parameter int NV_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flag_we,
  input  logic [3:0]         i_flag_mask,
  input  logic [3:0]         i_flag_in,
  input  logic               i_flag_save,
  input  logic               i_flag_restore,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [4*LANES-1:0] i_cond,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [LANES-1:0]   o_pass,
  output logic [3:0]         o_nzcv
);

  localparam logic c_NV_RESULT = (NV_MODE != 0);

  logic [3:0]       r_nzcv;
  logic [3:0]       r_shadow;
  logic [3:0]       w_base;
  logic [3:0]       w_wmask;
  logic [3:0]       w_next;
  logic [3:0]       w_eval_flags;
  logic [LANES-1:0] w_pass;
  logic             w_in_ready;

  // Restore selects the source first, then masked write bits override it.
  assign w_base  = i_flag_restore ? r_shadow : r_nzcv;
  assign w_wmask = {4{i_flag_we}} & i_flag_mask;
  assign w_next  = (w_base & ~w_wmask) | (i_flag_in & w_wmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nzcv   <= 4'b0000;
      r_shadow <= 4'b0000;
    end else begin
      r_nzcv <= w_next;
      if (i_flag_save) r_shadow <= r_nzcv;
    end
  end

  assign o_nzcv       = r_nzcv;
  assign w_eval_flags = (BYPASS != 0) ? w_next : r_nzcv;

  function automatic logic f_eval(input logic [3:0] cond, input logic [3:0] flg);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = flg;
    res = 1'b0;
    case (cond)
      4'h0: res = z;
      4'h1: res = !z;
      4'h2: res = c;
      4'h3: res = !c;
      4'h4: res = n;
      4'h5: res = !n;
      4'h6: res = v;
      4'h7: res = !v;
      4'h8: res = c && !z;
      4'h9: res = !c || z;
      4'hA: res = (n == v);
      4'hB: res = (n != v);
      4'hC: res = !z && (n == v);
      4'hD: res = z || (n != v);
      4'hE: res = 1'b1;
      default: res = c_NV_RESULT;
    endcase
    return res;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_pass[i] = f_eval(i_cond[4*i +: 4], w_eval_flags);
  end

  if (PIPE != 0) begin : g_pipe
    logic             r_out_valid;
    logic [LANES-1:0] r_pass;

    // A new accept may land in the same cycle the previous result drains.
    assign w_in_ready = !r_out_valid || i_out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_pass      <= '0;
      end else if (i_in_valid && w_in_ready) begin
        r_out_valid <= 1'b1;
        r_pass      <= w_pass;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end

    assign o_out_valid = r_out_valid;
    assign o_pass      = r_pass;
  end else begin : g_comb
    assign w_in_ready  = i_out_ready;
    assign o_out_valid = i_in_valid;
    assign o_pass      = w_pass;
  end

  assign o_in_ready = w_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cond_flag_unit
// Brief   : Directed vector bench for cond_flag_unit (bypass and non-bypass).
// Revision: 1.0
// ============================================================================
module tb_cond_flag_unit;

  logic       clk;
  logic       rst;
  logic       flag_we;
  logic [3:0] flag_mask;
  logic [3:0] flag_in;
  logic       flag_save;
  logic       flag_restore;
  logic       in_valid;
  logic [7:0] cond;
  logic       out_ready;

  logic       in_ready,  nb_in_ready;
  logic       out_valid, nb_out_valid;
  logic [1:0] pass,      nb_pass;
  logic [3:0] nzcv,      nb_nzcv;

  int total;
  int bad;

  cond_flag_unit #(.LANES(2), .PIPE(1), .BYPASS(1), .NV_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .i_flag_we(flag_we), .i_flag_mask(flag_mask),
    .i_flag_in(flag_in), .i_flag_save(flag_save), .i_flag_restore(flag_restore),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_cond(cond),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_pass(pass), .o_nzcv(nzcv)
  );

  cond_flag_unit #(.LANES(2), .PIPE(1), .BYPASS(0), .NV_MODE(0)) u_dut_nb (
    .clk(clk), .rst(rst), .i_flag_we(flag_we), .i_flag_mask(flag_mask),
    .i_flag_in(flag_in), .i_flag_save(flag_save), .i_flag_restore(flag_restore),
    .i_in_valid(in_valid), .o_in_ready(nb_in_ready), .i_cond(cond),
    .o_out_valid(nb_out_valid), .i_out_ready(out_ready), .o_pass(nb_pass), .o_nzcv(nb_nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic [7:0] cond;
    logic [1:0] exp;
  } vec_t;

  // Independent reference for the condition table, flags = {N,Z,C,V}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0: return f[2];
      4'h1: return ~f[2];
      4'h2: return f[1];
      4'h3: return ~f[1];
      4'h4: return f[3];
      4'h5: return ~f[3];
      4'h6: return f[0];
      4'h7: return ~f[0];
      4'h8: return f[1] & ~f[2];
      4'h9: return ~f[1] | f[2];
      4'hA: return ~(f[3] ^ f[0]);
      4'hB: return f[3] ^ f[0];
      4'hC: return ~f[2] & ~(f[3] ^ f[0]);
      4'hD: return f[2] | (f[3] ^ f[0]);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    flag_we = 0; flag_mask = 4'h0; flag_in = 4'h0;
    flag_save = 0; flag_restore = 0;
    in_valid = 0; cond = 8'h00; out_ready = 1;
  endtask

  task automatic write_flags(input logic [3:0] f);
    idle_inputs();
    flag_we = 1; flag_mask = 4'hF; flag_in = f;
    step();
  endtask

  vec_t vecs[13];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{4'b0000, 8'h10, 2'b10};
    vecs[1]  = '{4'b0100, 8'h10, 2'b01};
    vecs[2]  = '{4'b0010, 8'h32, 2'b01};
    vecs[3]  = '{4'b1000, 8'h54, 2'b01};
    vecs[4]  = '{4'b0001, 8'h76, 2'b01};
    vecs[5]  = '{4'b0010, 8'h98, 2'b01};
    vecs[6]  = '{4'b0110, 8'h98, 2'b10};
    vecs[7]  = '{4'b1001, 8'hBA, 2'b01};
    vecs[8]  = '{4'b1000, 8'hBA, 2'b10};
    vecs[9]  = '{4'b0000, 8'hDC, 2'b01};
    vecs[10] = '{4'b0101, 8'hDC, 2'b10};
    vecs[11] = '{4'b1111, 8'hFE, 2'b01};
    vecs[12] = '{4'b0000, 8'hFF, 2'b00};

    idle_inputs();
    rst = 1;
    step();
    // T1 reset
    check("rst_nzcv", {4'h0, nzcv}, 8'h00);
    check("rst_out_valid", {7'h0, out_valid}, 8'h00);
    check("rst_pass", {6'h0, pass}, 8'h00);
    rst = 0;
    in_valid = 1; cond = 8'h10;
    step();
    check("t1_pass", {6'h0, pass}, 8'h02);
    check("t1_out_valid", {7'h0, out_valid}, 8'h01);

    // Hand-computed table: write flags and evaluate in the same cycle (bypass)
    foreach (vecs[k]) begin
      idle_inputs();
      flag_we = 1; flag_mask = 4'hF; flag_in = vecs[k].flags;
      in_valid = 1; cond = vecs[k].cond;
      step();
      check($sformatf("vec%0d_pass", k), {6'h0, pass}, {6'h0, vecs[k].exp});
    end

    // T2 exhaustive sweep against the reference model
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] c0, c1, ff;
        c0 = c[3:0]; c1 = ~c0; ff = f[3:0];
        idle_inputs();
        flag_we = 1; flag_mask = 4'hF; flag_in = ff;
        in_valid = 1; cond = {c1, c0};
        step();
        check($sformatf("sweep_f%0h_c%0h", ff, c0), {6'h0, pass},
              {6'h0, ref_cond(c1, ff), ref_cond(c0, ff)});
      end
    end

    // T3 bypass vs registered flags
    write_flags(4'b0000);
    idle_inputs();
    flag_we = 1; flag_mask = 4'b0100; flag_in = 4'b0100;
    in_valid = 1; cond = 8'h10;
    step();
    check("t3_bypass_pass", {6'h0, pass}, 8'h01);
    check("t3_nobypass_pass", {6'h0, nb_pass}, 8'h02);
    idle_inputs();
    in_valid = 1; cond = 8'h10;
    step();
    check("t3_nobypass_next", {6'h0, nb_pass}, 8'h01);
    check("t3_nzcv", {4'h0, nzcv}, 8'h04);

    // T4 mask and shadow
    write_flags(4'b1010);
    idle_inputs(); flag_save = 1; step();
    idle_inputs(); flag_we = 1; flag_mask = 4'b1100; flag_in = 4'b0100; step();
    check("t4_masked", {4'h0, nzcv}, 8'h06);
    idle_inputs(); flag_we = 1; flag_mask = 4'b0000; flag_in = 4'b1111; step();
    check("t4_mask0", {4'h0, nzcv}, 8'h06);
    idle_inputs(); flag_restore = 1; step();
    check("t4_restore", {4'h0, nzcv}, 8'h0A);
    write_flags(4'b0001);
    idle_inputs(); flag_save = 1; step();
    write_flags(4'b1000);
    idle_inputs(); flag_save = 1; flag_restore = 1; step();
    check("t4_swap_nzcv", {4'h0, nzcv}, 8'h01);
    idle_inputs(); flag_restore = 1; step();
    check("t4_swap_shadow", {4'h0, nzcv}, 8'h08);

    // T5 stall: held result must survive flag writes and blocked inputs
    idle_inputs();
    flag_we = 1; flag_mask = 4'hF; flag_in = 4'b1001;
    in_valid = 1; cond = 8'hBA; out_ready = 0;
    step();
    check("t5_accept_valid", {7'h0, out_valid}, 8'h01);
    check("t5_accept_pass", {6'h0, pass}, 8'h01);
    flag_we = 1; flag_mask = 4'b0001; flag_in = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      step();
      flag_we = 0;
      check($sformatf("t5_stall%0d_pass", s), {6'h0, pass}, 8'h01);
      check($sformatf("t5_stall%0d_in_ready", s), {7'h0, in_ready}, 8'h00);
      check($sformatf("t5_stall%0d_valid", s), {7'h0, out_valid}, 8'h01);
    end
    check("t5_nzcv", {4'h0, nzcv}, 8'h08);
    out_ready = 1; cond = 8'hAB;
    #1;
    check("t5_release_in_ready", {7'h0, in_ready}, 8'h01);
    step();
    check("t5_new_pass", {6'h0, pass}, 8'h01);
    check("t5_new_valid", {7'h0, out_valid}, 8'h01);
    idle_inputs();
    step();
    check("t5_drain_valid", {7'h0, out_valid}, 8'h00);

    // T6 reset while a result is held
    write_flags(4'b1111);
    idle_inputs(); flag_save = 1; step();
    idle_inputs(); in_valid = 1; cond = 8'hEE; out_ready = 0; step();
    check("t6_held_valid", {7'h0, out_valid}, 8'h01);
    rst = 1;
    step();
    rst = 0;
    check("t6_rst_valid", {7'h0, out_valid}, 8'h00);
    check("t6_rst_nzcv", {4'h0, nzcv}, 8'h00);
    check("t6_rst_pass", {6'h0, pass}, 8'h00);
    idle_inputs(); flag_restore = 1; step();
    check("t6_rst_shadow", {4'h0, nzcv}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
